// File: rtl/pq_pkg.sv
// Shared types for the priority-queue stream bridge: the queue item and the bridge FSM state.
package pq_pkg;

  localparam int PQ_DATA_WIDTH = 32;
  localparam int PQ_TAG_WIDTH  = 32;

  typedef struct packed {
    logic [PQ_DATA_WIDTH-1:0] data;
    logic [PQ_TAG_WIDTH-1:0]  tag;
  } pq_item_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } pq_bridge_state_t;

endpackage

// File: rtl/pq_out_buf.sv
// Two-entry valid/ready FIFO of pq_item_t holding captured queue responses.
module pq_out_buf
  import pq_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       push_valid,
  input  pq_item_t   push_item,
  output logic       out_valid,
  input  logic       out_ready,
  output pq_item_t   out_item,
  output logic [1:0] count
);

  pq_item_t   mem_q [2];
  pq_item_t   mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       pop;
  logic       push;

  always_comb begin
    pop      = (count_q != 2'd0) && out_ready;
    // A full buffer can still take a push when the head leaves in the same cycle.
    push     = push_valid && ((count_q != 2'd2) || pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_item;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_item  = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/pq_stream_bridge.sv
// Stream-to-pulse adapter for the priority queue enq/deq port with a 2-entry response buffer.
// Optional PQ_BRIDGE_STATS_EN adds enq_count/deq_count outputs.
module pq_stream_bridge
  import pq_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [TAG_WIDTH-1:0]  s_tag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [TAG_WIDTH-1:0]  m_tag,
  output logic                  pq_enq,
  output logic [DATA_WIDTH-1:0] pq_enq_data,
  output logic [TAG_WIDTH-1:0]  pq_enq_tag,
  input  logic                  pq_full,
  output logic                  pq_deq,
  input  logic [DATA_WIDTH-1:0] pq_data_out,
  input  logic [TAG_WIDTH-1:0]  pq_tag_out,
  input  logic                  pq_empty,
  input  logic                  pq_valid_out,
  output logic                  err
`ifdef PQ_BRIDGE_STATS_EN
  ,
  output logic [31:0]           enq_count,
  output logic [31:0]           deq_count
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic GRANT_ENQ = 1'b0;
  localparam logic GRANT_DEQ = 1'b1;

  pq_bridge_state_t state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             last_grant_q, last_grant_d;
  logic             err_q, err_d;
  logic             want_enq, want_deq, grant_enq, grant_deq;
  logic             rsp_push;
  logic [1:0]       buf_count;
  pq_item_t         rsp_item;
  pq_item_t         head_item;

  always_comb begin
    want_deq  = (state_q == IDLE) && !pq_empty && (buf_count < 2'd2);
    want_enq  = s_valid && !pq_full;
    // Round robin: on a conflict the side that did not win last time gets the slot.
    grant_enq = want_enq && (!want_deq || (last_grant_q == GRANT_DEQ));
    grant_deq = want_deq && !grant_enq;
    s_ready   = grant_enq && !rst_in;
    pq_enq    = s_valid && s_ready;
    pq_deq    = grant_deq && !rst_in;
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    err_d        = err_q;
    last_grant_d = last_grant_q;
    rsp_push     = 1'b0;
    if (pq_enq) begin
      last_grant_d = GRANT_ENQ;
    end else if (pq_deq) begin
      last_grant_d = GRANT_DEQ;
    end
    case (state_q)
      IDLE: begin
        if (pq_valid_out) begin
          err_d = 1'b1;
        end
        if (pq_deq) begin
          state_d = WAIT_RSP;
          timer_d = TW'(TIMEOUT_CYCLES);
        end
      end
      WAIT_RSP: begin
        if (pq_valid_out) begin
          rsp_push = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
          if (timer_q == TW'(1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      err_q        <= 1'b0;
      last_grant_q <= GRANT_DEQ;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_item    = '{data: pq_data_out, tag: pq_tag_out};
  assign pq_enq_data = s_data;
  assign pq_enq_tag  = s_tag;
  assign err         = err_q;
  assign m_data      = head_item.data;
  assign m_tag       = head_item.tag;

  pq_out_buf u_out_buf (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push_valid (rsp_push),
    .push_item  (rsp_item),
    .out_valid  (m_valid),
    .out_ready  (m_ready),
    .out_item   (head_item),
    .count      (buf_count)
  );

`ifdef PQ_BRIDGE_STATS_EN
  logic [31:0] enq_count_q, deq_count_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      enq_count_q <= '0;
      deq_count_q <= '0;
    end else begin
      enq_count_q <= enq_count_q + {31'd0, pq_enq};
      deq_count_q <= deq_count_q + {31'd0, rsp_push};
    end
  end

  assign enq_count = enq_count_q;
  assign deq_count = deq_count_q;
`endif

endmodule
